// File: rtl/led_pkg.sv
// Shared definitions for the LED framebuffer scheduler: swap FSM encoding and
// the default framebuffer word size.
package led_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_SWAP  = 2'd2,
        S_ACK   = 2'd3
    } swap_state_e;

    localparam int unsigned C_WORD_BYTES_DFLT = 4;

endpackage

// File: rtl/led_fb_fetch.sv
// Framebuffer fetch engine: turns blitter coordinates into word fetch requests,
// with one pending request, a single-entry skid and an underrun counter.
module led_fb_fetch
    import led_pkg::*;
#(
    parameter int unsigned C_LED_CHAIN_LENGTH = 4,
    parameter int unsigned C_LED_WIDTH        = 32,
    parameter int unsigned C_LED_NBANKS       = 16,
    parameter int unsigned C_WORD_BYTES       = C_WORD_BYTES_DFLT,
    localparam int unsigned X_W = $clog2(C_LED_WIDTH * C_LED_CHAIN_LENGTH),
    localparam int unsigned Y_W = $clog2(C_LED_NBANKS)
) (
    input  logic           sys_clk,
    input  logic           sys_rst,
    input  logic [X_W-1:0] cur_x,
    input  logic [Y_W-1:0] cur_y,
    input  logic [31:0]    front_base,
    input  logic           rd_ready,
    output logic           rd_valid,
    output logic [31:0]    rd_addr,
    output logic [7:0]     underrun_count
);

    localparam logic [31:0] LINE_WORDS = 32'(C_LED_WIDTH * C_LED_CHAIN_LENGTH);
    localparam logic [31:0] WORD_BYTES = 32'(C_WORD_BYTES);

    logic [X_W+Y_W-1:0] coord, coord_q;
    logic               first_q;
    logic               valid_q, valid_d;
    logic [31:0]        addr_q, addr_d;
    logic               skid_valid_q, skid_valid_d;
    logic [31:0]        skid_addr_q, skid_addr_d;
    logic [7:0]         underrun_q, underrun_d;
    logic               trigger, retire;
    logic [31:0]        fetch_addr;

    assign coord = {cur_y, cur_x};

    always_comb begin
        trigger      = first_q | (coord != coord_q);
        retire       = valid_q & rd_ready;
        fetch_addr   = front_base + (32'(cur_y) * LINE_WORDS + 32'(cur_x)) * WORD_BYTES;
        valid_d      = valid_q;
        addr_d       = addr_q;
        skid_valid_d = skid_valid_q;
        skid_addr_d  = skid_addr_q;
        underrun_d   = underrun_q;
        if (valid_q && !retire) begin
            // Pending request must stay stable; newest coordinate wins the skid.
            if (trigger) begin
                skid_valid_d = 1'b1;
                skid_addr_d  = fetch_addr;
                if (underrun_q != 8'hFF) begin
                    underrun_d = underrun_q + 8'd1;
                end
            end
        end else if (trigger) begin
            valid_d      = 1'b1;
            addr_d       = fetch_addr;
            skid_valid_d = 1'b0;
        end else if (skid_valid_q) begin
            valid_d      = 1'b1;
            addr_d       = skid_addr_q;
            skid_valid_d = 1'b0;
        end else begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge sys_clk) begin
        coord_q <= coord;
        if (sys_rst) begin
            first_q      <= 1'b1;
            valid_q      <= 1'b0;
            addr_q       <= '0;
            skid_valid_q <= 1'b0;
            skid_addr_q  <= '0;
            underrun_q   <= '0;
        end else begin
            first_q      <= 1'b0;
            valid_q      <= valid_d;
            addr_q       <= addr_d;
            skid_valid_q <= skid_valid_d;
            skid_addr_q  <= skid_addr_d;
            underrun_q   <= underrun_d;
        end
    end

    assign rd_valid       = valid_q;
    assign rd_addr        = addr_q;
    assign underrun_count = underrun_q;

endmodule

// File: rtl/led_fb_scheduler.sv
// LED framebuffer scheduler: double-buffer swap handshake synchronised to vsync,
// frame counting, and the fetch engine reading from the current front buffer.
module led_fb_scheduler
    import led_pkg::*;
#(
    parameter int unsigned C_LED_CHAIN_LENGTH = 4,
    parameter int unsigned C_LED_WIDTH        = 32,
    parameter int unsigned C_LED_NBANKS       = 16,
    parameter int unsigned C_WORD_BYTES       = C_WORD_BYTES_DFLT,
    localparam int unsigned X_W = $clog2(C_LED_WIDTH * C_LED_CHAIN_LENGTH),
    localparam int unsigned Y_W = $clog2(C_LED_NBANKS)
) (
    input  logic           sys_clk,
    input  logic           sys_rst,
    input  logic [31:0]    cfg_bufa_base,
    input  logic [31:0]    cfg_bufb_base,
    input  logic           host_swap_req,
    output logic           host_swap_ack,
    input  logic           ctl_vsync,
    input  logic [X_W-1:0] ctl_cur_x,
    input  logic [Y_W-1:0] ctl_cur_y,
    output logic           rd_valid,
    input  logic           rd_ready,
    output logic [31:0]    rd_addr,
    output logic           front_sel,
    output logic [31:0]    back_base,
    output logic [15:0]    frame_count,
    output logic [7:0]     underrun_count
);

    swap_state_e state_q, state_d;
    logic        vsync_q, vsync_rise;
    logic        front_sel_q, front_sel_d;
    logic [31:0] front_base_q, front_base_d;
    logic [31:0] back_base_q, back_base_d;
    logic        ack_q, ack_d;
    logic [15:0] frame_q, frame_d;

    always_comb begin
        vsync_rise   = ctl_vsync & ~vsync_q;
        state_d      = state_q;
        front_sel_d  = front_sel_q;
        front_base_d = front_base_q;
        back_base_d  = back_base_q;
        frame_d      = frame_q + 16'(vsync_rise);
        unique case (state_q)
            S_IDLE:  if (host_swap_req) state_d = S_ARMED;
            S_ARMED: begin
                if (!host_swap_req) begin
                    state_d = S_IDLE;
                end else if (vsync_rise) begin
                    state_d = S_SWAP;
                end
            end
            S_SWAP: begin
                // Old front becomes the host-writable back buffer.
                front_sel_d  = ~front_sel_q;
                front_base_d = front_sel_q ? cfg_bufa_base : cfg_bufb_base;
                back_base_d  = front_sel_q ? cfg_bufb_base : cfg_bufa_base;
                state_d      = S_ACK;
            end
            S_ACK:   if (!host_swap_req) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        ack_d = (state_d == S_ACK);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q      <= S_IDLE;
            vsync_q      <= 1'b0;
            front_sel_q  <= 1'b0;
            front_base_q <= cfg_bufa_base;
            back_base_q  <= cfg_bufb_base;
            ack_q        <= 1'b0;
            frame_q      <= '0;
        end else begin
            state_q      <= state_d;
            vsync_q      <= ctl_vsync;
            front_sel_q  <= front_sel_d;
            front_base_q <= front_base_d;
            back_base_q  <= back_base_d;
            ack_q        <= ack_d;
            frame_q      <= frame_d;
        end
    end

    // Next-state base so a fetch triggered during the swap cycle uses the new front.
    led_fb_fetch #(
        .C_LED_CHAIN_LENGTH (C_LED_CHAIN_LENGTH),
        .C_LED_WIDTH        (C_LED_WIDTH),
        .C_LED_NBANKS       (C_LED_NBANKS),
        .C_WORD_BYTES       (C_WORD_BYTES)
    ) u_fetch (
        .sys_clk        (sys_clk),
        .sys_rst        (sys_rst),
        .cur_x          (ctl_cur_x),
        .cur_y          (ctl_cur_y),
        .front_base     (front_base_d),
        .rd_ready       (rd_ready),
        .rd_valid       (rd_valid),
        .rd_addr        (rd_addr),
        .underrun_count (underrun_count)
    );

    assign host_swap_ack = ack_q;
    assign front_sel     = front_sel_q;
    assign back_base     = back_base_q;
    assign frame_count   = frame_q;

endmodule

// File: tb/tb_led_fb_scheduler.sv
// Bench for led_fb_scheduler: queue-based fetch reference model with a negedge
// monitor, plus directed swap handshake and reset sequences.
module tb_led_fb_scheduler;

    localparam int W  = 32;
    localparam int L  = 4;
    localparam int NB = 16;
    localparam int WB = 4;
    localparam logic [31:0] BASE_A = 32'h1000_0000;
    localparam logic [31:0] BASE_B = 32'h1010_0000;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic [31:0] cfg_bufa_base, cfg_bufb_base;
    logic        host_swap_req, host_swap_ack;
    logic        ctl_vsync;
    logic [6:0]  ctl_cur_x;
    logic [3:0]  ctl_cur_y;
    logic        rd_valid, rd_ready;
    logic [31:0] rd_addr;
    logic        front_sel;
    logic [31:0] back_base;
    logic [15:0] frame_count;
    logic [7:0]  underrun_count;

    int checks = 0;
    int errors = 0;
    int exp_frames = 0;
    int ack_cnt = 0;
    bit mon_en = 1'b0;

    // Reference model state: outstanding fetches in issue order (head is presented).
    logic [31:0] mq[$];
    int          m_ud = 0;
    bit          m_first = 1'b1;
    logic [10:0] m_prev;
    logic [31:0] m_front = BASE_A;

    always #5 sys_clk = ~sys_clk;

    led_fb_scheduler dut (
        .sys_clk        (sys_clk),
        .sys_rst        (sys_rst),
        .cfg_bufa_base  (cfg_bufa_base),
        .cfg_bufb_base  (cfg_bufb_base),
        .host_swap_req  (host_swap_req),
        .host_swap_ack  (host_swap_ack),
        .ctl_vsync      (ctl_vsync),
        .ctl_cur_x      (ctl_cur_x),
        .ctl_cur_y      (ctl_cur_y),
        .rd_valid       (rd_valid),
        .rd_ready       (rd_ready),
        .rd_addr        (rd_addr),
        .front_sel      (front_sel),
        .back_base      (back_base),
        .frame_count    (frame_count),
        .underrun_count (underrun_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a new fetch goes out if nothing is outstanding or the head retires now;
    // otherwise it waits behind the head, replacing any older waiting one.
    always @(posedge sys_clk) begin
        if (sys_rst) begin
            mq.delete();
            m_ud    = 0;
            m_first = 1'b1;
            m_prev  = {ctl_cur_y, ctl_cur_x};
            m_front = cfg_bufa_base;
        end else begin
            bit          trig, busy, retire;
            logic [31:0] a;
            trig    = m_first || ({ctl_cur_y, ctl_cur_x} != m_prev);
            m_prev  = {ctl_cur_y, ctl_cur_x};
            m_first = 1'b0;
            a       = m_front + (int'(ctl_cur_y) * W * L + int'(ctl_cur_x)) * WB;
            busy    = mq.size() > 0;
            retire  = busy && rd_ready;
            if (retire) void'(mq.pop_front());
            if (trig) begin
                if (busy && !retire) begin
                    if (mq.size() == 2) mq[1] = a;
                    else mq.push_back(a);
                    if (m_ud < 255) m_ud++;
                end else begin
                    mq.delete();
                    mq.push_back(a);
                end
            end
        end
    end

    always @(negedge sys_clk) begin
        if (mon_en) begin
            chk("rd_valid", 32'(rd_valid), 32'(mq.size() > 0));
            if (rd_valid && mq.size() > 0) chk("rd_addr", rd_addr, mq[0]);
            chk("underrun_count", 32'(underrun_count), 32'(m_ud));
            if (host_swap_ack) ack_cnt++;
        end
    end

    task automatic tick();
        @(posedge sys_clk);
        #2;
    endtask

    task automatic set_vsync(input logic v);
        if (v && !ctl_vsync) exp_frames++;
        ctl_vsync = v;
    endtask

    // Runs a full arm/vsync/swap sequence, leaving the FSM in S_ACK with req high.
    task automatic swap_to_ack();
        host_swap_req = 1'b1;
        repeat (3) tick();
        set_vsync(1'b1);
        repeat (2) tick();
        set_vsync(1'b0);
        repeat (2) tick();
        m_front = (m_front == BASE_A) ? BASE_B : BASE_A;
    endtask

    initial begin
        sys_rst       = 1'b1;
        cfg_bufa_base = BASE_A;
        cfg_bufb_base = BASE_B;
        host_swap_req = 1'b0;
        ctl_vsync     = 1'b0;
        ctl_cur_x     = '0;
        ctl_cur_y     = '0;
        rd_ready      = 1'b1;
        repeat (3) tick();
        @(negedge sys_clk);
        chk("rst_front_sel", 32'(front_sel), 32'd0);
        chk("rst_back_base", back_base, BASE_B);
        chk("rst_ack", 32'(host_swap_ack), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_rd_addr", rd_addr, 32'd0);
        chk("rst_frame", 32'(frame_count), 32'd0);
        chk("rst_underrun", 32'(underrun_count), 32'd0);
        mon_en = 1'b1;

        // First fetch after release: visible on the second cycle.
        tick();
        sys_rst = 1'b0;
        @(negedge sys_clk);
        chk("first_valid_c1", 32'(rd_valid), 32'd0);
        tick();
        @(negedge sys_clk);
        chk("first_valid_c2", 32'(rd_valid), 32'd1);
        chk("first_addr", rd_addr, 32'h1000_0000);

        // Address arithmetic.
        tick();
        ctl_cur_x = 7'd5;
        ctl_cur_y = 4'd2;
        tick();
        @(negedge sys_clk);
        chk("xy_valid", 32'(rd_valid), 32'd1);
        chk("xy_addr", rd_addr, 32'h1000_0414);

        // Back-pressure: 3 held, 4 then 5 into skid, 5 issued after ready.
        tick();
        rd_ready  = 1'b0;
        ctl_cur_y = 4'd0;
        ctl_cur_x = 7'd3;
        tick();
        ctl_cur_x = 7'd4;
        tick();
        ctl_cur_x = 7'd5;
        tick();
        @(negedge sys_clk);
        chk("held_addr", rd_addr, BASE_A + 32'd12);
        chk("held_underrun", 32'(underrun_count), 32'd2);
        tick();
        rd_ready = 1'b1;
        tick();
        @(negedge sys_clk);
        chk("skid_valid", 32'(rd_valid), 32'd1);
        chk("skid_addr", rd_addr, BASE_A + 32'd20);
        tick();
        @(negedge sys_clk);
        chk("skid_drained", 32'(rd_valid), 32'd0);

        // Aborted request: no swap, no ack.
        tick();
        host_swap_req = 1'b1;
        repeat (4) tick();
        host_swap_req = 1'b0;
        repeat (2) tick();
        set_vsync(1'b1);
        repeat (3) tick();
        set_vsync(1'b0);
        repeat (3) tick();
        @(negedge sys_clk);
        chk("abort_ack_seen", 32'(ack_cnt), 32'd0);
        chk("abort_front_sel", 32'(front_sel), 32'd0);
        chk("abort_frame", 32'(frame_count), 32'(exp_frames));

        // Full swap; coordinate change lands in the swap cycle and must use base B.
        tick();
        host_swap_req = 1'b1;
        repeat (10) tick();
        set_vsync(1'b1);
        tick();
        ctl_cur_x = 7'd7;
        ctl_cur_y = 4'd1;
        m_front   = BASE_B;
        @(negedge sys_clk);
        chk("swap_front_early", 32'(front_sel), 32'd0);
        chk("swap_ack_early", 32'(host_swap_ack), 32'd0);
        tick();
        set_vsync(1'b0);
        @(negedge sys_clk);
        chk("swap_front_sel", 32'(front_sel), 32'd1);
        chk("swap_ack", 32'(host_swap_ack), 32'd1);
        chk("swap_back_base", back_base, BASE_A);
        chk("swap_fetch_addr", rd_addr, 32'h1010_021C);
        tick();
        @(negedge sys_clk);
        chk("swap_ack_held", 32'(host_swap_ack), 32'd1);
        tick();
        host_swap_req = 1'b0;
        tick();
        @(negedge sys_clk);
        chk("swap_ack_drop", 32'(host_swap_ack), 32'd0);
        chk("swap_frame", 32'(frame_count), 32'(exp_frames));

        // Random coordinates, back-pressure and vsync; monitor checks every cycle.
        for (int i = 0; i < 400; i++) begin
            tick();
            if ($urandom_range(0, 2) == 0) begin
                ctl_cur_x = 7'($urandom_range(0, 127));
                ctl_cur_y = 4'($urandom_range(0, 15));
            end
            rd_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) == 0) set_vsync(~ctl_vsync);
        end
        tick();
        set_vsync(1'b0);
        rd_ready = 1'b1;
        repeat (4) tick();
        @(negedge sys_clk);
        chk("rand_frame", 32'(frame_count), 32'(exp_frames));
        chk("rand_drained", 32'(rd_valid), 32'd0);

        // Swap back to A, then reset in the middle of a later handshake and fetch.
        swap_to_ack();
        host_swap_req = 1'b0;
        repeat (2) tick();
        @(negedge sys_clk);
        chk("swap2_front_sel", 32'(front_sel), 32'd0);
        chk("swap2_back_base", back_base, BASE_B);
        tick();
        rd_ready  = 1'b0;
        ctl_cur_x = 7'd10;
        ctl_cur_y = 4'd3;
        tick();
        ctl_cur_x = 7'd11;
        repeat (2) tick();
        swap_to_ack();
        @(negedge sys_clk);
        chk("pre_rst_ack", 32'(host_swap_ack), 32'd1);
        chk("pre_rst_valid", 32'(rd_valid), 32'd1);
        chk("pre_rst_front", 32'(front_sel), 32'd1);
        tick();
        sys_rst    = 1'b1;
        exp_frames = 0;
        tick();
        @(negedge sys_clk);
        chk("mid_rst_ack", 32'(host_swap_ack), 32'd0);
        chk("mid_rst_valid", 32'(rd_valid), 32'd0);
        chk("mid_rst_front", 32'(front_sel), 32'd0);
        chk("mid_rst_frame", 32'(frame_count), 32'd0);
        chk("mid_rst_underrun", 32'(underrun_count), 32'd0);
        chk("mid_rst_back", back_base, BASE_B);
        tick();
        sys_rst  = 1'b0;
        rd_ready = 1'b1;
        repeat (4) tick();
        @(negedge sys_clk);
        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_fb_scheduler.md
LED_FB_SCHEDULER -- requirements
Module: led_fb_scheduler

Interface
REQ-001 C_LED_CHAIN_LENGTH, 4, displays per chain.
REQ-002 C_LED_WIDTH, 32, pixels per display line.
REQ-003 C_LED_NBANKS, 16, banks (lines) per chain.
REQ-004 C_WORD_BYTES, 4, bytes per framebuffer word (one word per pixel column per bank).
REQ-005 sys_clk  in  1  single clock; all logic on rising edge.
REQ-006 sys_rst  in  1  reset, synchronous, active-high.
REQ-007 cfg_bufa_base / cfg_bufb_base  in  32 each  byte base of buffer A / B; sampled only in S_SWAP and at reset release.
REQ-008 host_swap_req / host_swap_ack  in / out  1  four-phase swap handshake.
REQ-009 ctl_vsync  in  1  frame-boundary pulse from blitter (multi-cycle high).
REQ-010 ctl_cur_x  in  $clog2(C_LED_WIDTH*C_LED_CHAIN_LENGTH)  blitter column.
REQ-011 ctl_cur_y  in  $clog2(C_LED_NBANKS)  blitter bank.
REQ-012 rd_valid / rd_ready  out / in  1  fetch request handshake to memory port.
REQ-013 rd_addr  out  32  byte address of fetched word.
REQ-014 front_sel  out  1  0 = blitter reads A, 1 = reads B; back_base  out  32  base of buffer host may write.
REQ-015 frame_count  out  16  vsync rising edges seen, wraps at 0xFFFF->0; underrun_count  out  8  saturating.

Function
REQ-016 Swap FSM states S_IDLE, S_ARMED, S_SWAP, S_ACK; S_IDLE->S_ARMED when host_swap_req=1.
REQ-017 S_ARMED->S_SWAP on cycle after vsync rising edge (ctl_vsync=1, registered previous=0); level-high vsync at arming time is not an edge.
REQ-018 S_SWAP lasts one cycle: front_sel toggles, back_base updates to base of new back buffer, then ->S_ACK.
REQ-019 S_ACK drives host_swap_ack=1; ->S_IDLE when host_swap_req=0, ack deasserts same transition; host_swap_ack=0 in every other state.
REQ-020 host_swap_req dropping in S_ARMED aborts: ->S_IDLE, no swap, no ack.
REQ-021 front_sel changes only in S_SWAP, hence only at frame boundaries; never mid-frame.
REQ-022 Fetch address = front base + ((ctl_cur_y*C_LED_WIDTH*C_LED_CHAIN_LENGTH + ctl_cur_x) * C_WORD_BYTES), 32-bit modulo arithmetic, registered (one-cycle latency from coordinate change to rd_valid).
REQ-023 New fetch triggered when registered {ctl_cur_y,ctl_cur_x} differs from previous value, and once on first cycle after reset release.
REQ-024 rd_valid held with rd_addr stable until rd_ready=1; request retires on cycle where rd_valid&rd_ready.
REQ-025 Trigger while request pending: pending request completes unchanged; newest coordinates latched into single-entry skid; skid issued next cycle after retire; underrun_count +1 (saturate 255).
REQ-026 Further trigger while skid full overwrites skid (newest wins), underrun_count +1.
REQ-027 Trigger and retire in same cycle: new request issued next cycle, no underrun.
REQ-028 Swap in S_SWAP coinciding with a trigger: fetch uses new front base.
REQ-029 frame_count increments on each vsync rising edge regardless of FSM state.

Reset
REQ-030 On sys_rst=1 at clock edge: FSM S_IDLE, front_sel=0, back_base=cfg_bufb_base, host_swap_ack=0, rd_valid=0, rd_addr=0, skid empty, frame_count=0, underrun_count=0, vsync edge register=0.
REQ-031 Reset asserted mid-handshake or mid-fetch abandons it immediately; no ack or rd_valid on the following cycle.

Structure
REQ-032 Shared package led_pkg holds swap FSM state encodings and C_WORD_BYTES default; geometry parameters stay module parameters matching blitter.
REQ-033 Fetch logic (address calc, pending register, skid, underrun counter) is sub-module led_fb_fetch; swap FSM and counters stay in top.

Verification
REQ-034 Reset, bases A=0x1000_0000 B=0x1010_0000, x=0,y=0 -> rd_addr=0x1000_0000, rd_valid=1 second cycle after release.
REQ-035 Req=1, vsync pulse 10 cycles later -> front_sel=1 one cycle after edge+1, ack=1 next; req=0 -> ack=0 next cycle; back_base=0x1000_0000.
REQ-036 Req=1 then req=0 before vsync -> no swap, ack never asserts, front_sel stays 0.
REQ-037 x=5,y=2, default geometry, front A -> rd_addr=0x1000_0000+(2*128+5)*4=0x1000_0414.
REQ-038 rd_ready=0, x steps 3,4,5 -> request 3 held, skid holds 5, underrun_count=2, then 5 issued after ready.
REQ-039 sys_rst pulsed during S_ACK with rd_valid=1 -> ack=0, rd_valid=0, front_sel=0, counters=0 next cycle.
